// File: rtl/kirsch_pkg.sv
// rtl/kirsch_pkg.sv - shared constants and pixel type for the Kirsch 3x3 window
package kirsch_pkg;

  localparam int DATA_W         = 8;
  localparam int DEF_IMG_WIDTH  = 64;
  localparam int DEF_IMG_HEIGHT = 64;
  localparam int COL_W          = $clog2(DEF_IMG_WIDTH);
  localparam int ROW_W          = $clog2(DEF_IMG_HEIGHT);

  typedef logic [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/kirsch_line_buffer.sv
// rtl/kirsch_line_buffer.sv - enable-gated fixed-delay line buffer
// Output is the pixel accepted exactly DEPTH enables ago; contents are never cleared.
module kirsch_line_buffer #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/kirsch_window_3x3.sv
// rtl/kirsch_window_3x3.sv - raster pixel stream to sliding 3x3 window
// Only interior windows (row >= 2, col >= 2) are flagged valid; borders are not padded.
module kirsch_window_3x3
  import kirsch_pkg::*;
#(
  parameter int IMG_WIDTH  = kirsch_pkg::DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = kirsch_pkg::DEF_IMG_HEIGHT,
  parameter int DATA_W     = kirsch_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4,
  output logic [DATA_W-1:0] p5,
  output logic [DATA_W-1:0] p6,
  output logic [DATA_W-1:0] p7,
  output logic [DATA_W-1:0] p8,
  output logic [DATA_W-1:0] p9,
  output logic              win_valid,
  output logic              frame_done
);

  localparam int CNT_COL_W = $clog2(IMG_WIDTH);
  localparam int CNT_ROW_W = $clog2(IMG_HEIGHT);

  logic [CNT_COL_W-1:0] col_q, col_d;
  logic [CNT_ROW_W-1:0] row_q, row_d;
  logic [DATA_W-1:0]    win_q [3][3];
  logic [DATA_W-1:0]    win_d [3][3];
  logic                 win_valid_q, win_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic [DATA_W-1:0]    lb0_dout, lb1_dout;
  logic                 last_col, last_row;

  kirsch_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb0 (
    .clk (clk),
    .en  (pix_valid),
    .din (pix_in),
    .dout(lb0_dout)
  );

  kirsch_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_W(DATA_W)) u_lb1 (
    .clk (clk),
    .en  (pix_valid),
    .din (lb0_dout),
    .dout(lb1_dout)
  );

  assign last_col = (col_q == CNT_COL_W'(IMG_WIDTH - 1));
  assign last_row = (row_q == CNT_ROW_W'(IMG_HEIGHT - 1));

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      // New right column: (r-2,c), (r-1,c), (r,c)
      win_d[0][2]  = lb1_dout;
      win_d[1][2]  = lb0_dout;
      win_d[2][2]  = pix_in;
      win_valid_d  = (row_q >= CNT_ROW_W'(2)) && (col_q >= CNT_COL_W'(2));
      frame_done_d = last_col && last_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  assign p1 = win_q[0][0];
  assign p2 = win_q[0][1];
  assign p3 = win_q[0][2];
  assign p4 = win_q[1][0];
  assign p5 = win_q[1][1];
  assign p6 = win_q[1][2];
  assign p7 = win_q[2][0];
  assign p8 = win_q[2][1];
  assign p9 = win_q[2][2];

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/kirsch_window_3x3.md
Name: kirsch_window_3x3

Overview:
- Converts a raster-order 8-bit pixel stream into a sliding 3x3 neighbourhood, one window per accepted pixel once two full rows and two columns are buffered.
- Sits directly upstream of the Kirsch compass-kernel datapaths (AMSG stages) and drives their p1..p9 inputs; p5, the centre, is provided for kernels that use it.
- Uses two line buffers plus a 3x3 register array; borders are not padded, so only interior windows are flagged valid.

Parameters:
- IMG_WIDTH, 64, pixels per row; legal values >= 3.
- IMG_HEIGHT, 64, rows per frame; legal values >= 3.
- DATA_W, 8, bits per pixel.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  DATA_W  incoming pixel, raster order, row 0 first.
- pix_valid  in  1  pix_in is accepted on every cycle this is high; there is no backpressure.
- p1, p2, p3  out  DATA_W  window top row, left to right.
- p4, p5, p6  out  DATA_W  window middle row; p5 is the centre.
- p7, p8, p9  out  DATA_W  window bottom row.
- win_valid  out  1  p1..p9 hold a complete interior window this cycle.
- frame_done  out  1  one-cycle pulse, coincident with the last window of the frame.

Behaviour:
- Reset: col and row counters = 0; the 3x3 window registers, p1..p9, win_valid and frame_done all = 0.
  - Line-buffer contents are not cleared. They are don't-care because win_valid cannot assert until row 2 has been refilled.
- Reset mid-frame: same as reset. The next accepted pixel is treated as (row 0, col 0).
- Counters: col counts 0..IMG_WIDTH-1, row counts 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels.
  - col wraps to 0 and increments row.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and the next frame starts.
- Line buffers:
  - lb0 delays each accepted pixel by exactly IMG_WIDTH accepted pixels and outputs pixel (r-1, c).
  - lb1 is fed from lb0's output and outputs pixel (r-2, c).
  - Both buffers shift only on accepted pixels.
- Window update, per accepted pixel (r, c):
  - All three window rows shift one column left.
  - The new right column becomes {lb1 out, lb0 out, pix_in}, i.e. pixels (r-2, c), (r-1, c), (r, c).
- Output mapping: p1..p9 are the window registers read directly. p1 = (r-2, c-2), p5 = (r-1, c-1), p9 = (r, c).
- win_valid: registered. It goes high the cycle after accepting pixel (r, c) with r >= 2 and c >= 2.
  - Latency is 1 clock from acceptance to the window appearing on p1..p9.
- Window count: (IMG_WIDTH-2) * (IMG_HEIGHT-2) windows per frame.
- Across row boundaries: windows at c = 0 and c = 1 are flagged invalid. Their register contents span two rows and are don't-care.
- Stall (pix_valid = 0):
  - Counters, line buffers and window registers hold.
  - p1..p9 hold their last value.
  - win_valid = 0 and frame_done = 0 on the next cycle.
- frame_done: high in the same cycle as win_valid for the window produced by pixel (IMG_HEIGHT-1, IMG_WIDTH-1). Low otherwise.
- Back-to-back frames need no idle gap. Stale rows from the previous frame never produce a valid window.
- Arithmetic: none on pixel data. Pixel values pass through bit-exact.

Decomposition:
- Shared package kirsch_pkg holds:
  - DATA_W, and the default IMG_WIDTH and IMG_HEIGHT;
  - COL_W = $clog2(IMG_WIDTH) and ROW_W = $clog2(IMG_HEIGHT);
  - the pixel_t typedef.
- One natural sub-module: kirsch_line_buffer (parameters DEPTH and DATA_W; ports clk, en, din, dout). It is a fixed-delay enable-gated shift register or circular RAM, instantiated twice.
- Counters, window registers and flag logic stay in the top module.

Test Plan:
All scenarios use IMG_WIDTH = 5 and IMG_HEIGHT = 4, with pixel value = row*16 + col.
- Continuous stream, one full frame:
  - The first win_valid comes 1 cycle after the 13th pixel (0x22), with p1..p9 = 00, 01, 02, 10, 11, 12, 20, 21, 22.
  - Exactly 6 win_valid cycles occur in the frame.
- Last window of the frame: p1..p9 = 12, 13, 14, 22, 23, 24, 32, 33, 34, with frame_done = 1 in that same cycle only.
- Random pix_valid gaps (about 40% idle): the same 6 windows appear with identical p1..p9 values and in the same order. win_valid is never high one cycle after an idle cycle.
- Reset asserted after pixel 0x21, then a fresh frame: all outputs are 0 during reset. The first window again comes after the 13th new pixel, with the values from scenario 1.
- Two frames back-to-back, the second with pixel value + 0x80: the second frame's first window is 80, 81, 82, 90, 91, 92, A0, A1, A2, with no first-frame data in any valid window.
- Row-boundary check: no win_valid follows pixels (2,0), (2,1), (3,0) or (3,1). The window after (3,2) is 10, 11, 12, 20, 21, 22, 30, 31, 32.
